// File: rtl/pcie_wrap0_master_0_packets_to_bytes_pkg.sv
// Shared framing constants and FSM encoding for the Avalon-ST byte-stream
// packetiser/depacketiser pair.
package pcie_wrap0_master_0_packets_to_bytes_pkg;

  localparam logic [7:0] SOP_CHAR  = 8'h7A;
  localparam logic [7:0] EOP_CHAR  = 8'h7B;
  localparam logic [7:0] CHAN_CHAR = 8'h7C;
  localparam logic [7:0] ESC_CHAR  = 8'h7D;
  localparam logic [7:0] ESC_XOR   = 8'h20;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_CH       = 3'd1,
    S_CH_ESC   = 3'd2,
    S_CH_VAL   = 3'd3,
    S_SOP      = 3'd4,
    S_EOP      = 3'd5,
    S_DATA_ESC = 3'd6,
    S_DATA     = 3'd7
  } state_t;

  function automatic logic is_special(input logic [7:0] b);
    return (b >= SOP_CHAR) && (b <= ESC_CHAR);
  endfunction

endpackage

// File: rtl/pcie_wrap0_st_byte_escape.sv
// Combinational classifier: flags framing characters and supplies their
// escaped (xor 0x20) form.
module pcie_wrap0_st_byte_escape
  import pcie_wrap0_master_0_packets_to_bytes_pkg::*;
(
  input  logic [7:0] i_byte,
  output logic       o_is_special,
  output logic [7:0] o_escaped
);

  assign o_is_special = is_special(i_byte);
  assign o_escaped    = i_byte ^ ESC_XOR;

endmodule

// File: rtl/pcie_wrap0_master_0_packets_to_bytes.sv
// Serialises Avalon-ST packet beats into a framed, escaped byte stream using
// in-band SOP/EOP/CHANNEL/ESCAPE characters.
module pcie_wrap0_master_0_packets_to_bytes
  import pcie_wrap0_master_0_packets_to_bytes_pkg::*;
#(
  parameter int CHANNEL_WIDTH         = 8,
  parameter bit RESEND_CHANNEL_ON_SOP = 1'b0
) (
  input  logic                     clk,
  input  logic                     reset,
  output logic                     in_ready,
  input  logic                     in_valid,
  input  logic [7:0]               in_data,
  input  logic [CHANNEL_WIDTH-1:0] in_channel,
  input  logic                     in_startofpacket,
  input  logic                     in_endofpacket,
  input  logic                     out_ready,
  output logic                     out_valid,
  output logic [7:0]               out_data
);

  state_t     r_state;
  state_t     w_nxt_state;
  state_t     w_data_state;
  state_t     w_first_state;
  logic       r_hold_valid;
  logic       r_sop;
  logic       r_eop;
  logic       r_last_ch_valid;
  logic [7:0] r_ch;
  logic [7:0] r_data;
  logic [7:0] r_last_ch;
  logic [7:0] r_out_data;
  logic       w_in_acc;
  logic       w_out_acc;
  logic       w_final_acc;
  logic       w_send_ch;
  logic       w_nxt_sop;
  logic       w_nxt_eop;
  logic       w_ch_spc;
  logic       w_data_spc;
  logic [7:0] w_nxt_ch;
  logic [7:0] w_nxt_data;
  logic [7:0] w_ch_x;
  logic [7:0] w_data_x;

  function automatic logic [7:0] state_byte(
    input state_t     s,
    input logic [7:0] ch,
    input logic       ch_spc,
    input logic [7:0] ch_x,
    input logic [7:0] d,
    input logic       d_spc,
    input logic [7:0] d_x
  );
    case (s)
      S_CH:                 return CHAN_CHAR;
      S_CH_ESC, S_DATA_ESC: return ESC_CHAR;
      S_CH_VAL:             return ch_spc ? ch_x : ch;
      S_SOP:                return SOP_CHAR;
      S_EOP:                return EOP_CHAR;
      S_DATA:               return d_spc ? d_x : d;
      default:              return 8'h00;
    endcase
  endfunction

  assign w_out_acc   = out_valid && out_ready;
  assign w_final_acc = (r_state == S_DATA) && out_ready;
  assign in_ready    = !r_hold_valid || w_final_acc;
  assign w_in_acc    = in_valid && in_ready;
  assign out_valid   = (r_state != S_IDLE);
  assign out_data    = r_out_data;

  // Beat that drives next-state decode: a newly accepted one wins over the held one
  always_comb begin
    w_nxt_ch   = r_ch;
    w_nxt_data = r_data;
    w_nxt_sop  = r_sop;
    w_nxt_eop  = r_eop;
    if (w_in_acc) begin
      w_nxt_ch   = 8'(in_channel);
      w_nxt_data = in_data;
      w_nxt_sop  = in_startofpacket;
      w_nxt_eop  = in_endofpacket;
    end else begin
      w_nxt_ch   = r_ch;
      w_nxt_data = r_data;
      w_nxt_sop  = r_sop;
      w_nxt_eop  = r_eop;
    end
  end

  pcie_wrap0_st_byte_escape u_ch_esc (
    .i_byte       (w_nxt_ch),
    .o_is_special (w_ch_spc),
    .o_escaped    (w_ch_x)
  );

  pcie_wrap0_st_byte_escape u_data_esc (
    .i_byte       (w_nxt_data),
    .o_is_special (w_data_spc),
    .o_escaped    (w_data_x)
  );

  // Next state: skip framing bytes the held beat does not need
  always_comb begin
    w_send_ch     = !r_last_ch_valid || (w_nxt_ch != r_last_ch) ||
                    (RESEND_CHANNEL_ON_SOP && w_nxt_sop);
    w_data_state  = w_data_spc ? S_DATA_ESC : S_DATA;
    w_first_state = w_send_ch ? S_CH : (w_nxt_sop ? S_SOP : (w_nxt_eop ? S_EOP : w_data_state));
    w_nxt_state   = r_state;
    if (w_in_acc) begin
      w_nxt_state = w_first_state;
    end else if (w_out_acc) begin
      case (r_state)
        S_CH:       w_nxt_state = w_ch_spc ? S_CH_ESC : S_CH_VAL;
        S_CH_ESC:   w_nxt_state = S_CH_VAL;
        S_CH_VAL:   w_nxt_state = w_nxt_sop ? S_SOP : (w_nxt_eop ? S_EOP : w_data_state);
        S_SOP:      w_nxt_state = w_nxt_eop ? S_EOP : w_data_state;
        S_EOP:      w_nxt_state = w_data_state;
        S_DATA_ESC: w_nxt_state = S_DATA;
        default:    w_nxt_state = S_IDLE;
      endcase
    end else begin
      w_nxt_state = r_state;
    end
  end

  // Holding register, channel tracking and registered output byte
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state         <= S_IDLE;
      r_hold_valid    <= 1'b0;
      r_last_ch_valid <= 1'b0;
      r_last_ch       <= 8'h00;
      r_ch            <= 8'h00;
      r_data          <= 8'h00;
      r_sop           <= 1'b0;
      r_eop           <= 1'b0;
      r_out_data      <= 8'h00;
    end else begin
      r_state    <= w_nxt_state;
      r_out_data <= state_byte(w_nxt_state, w_nxt_ch, w_ch_spc, w_ch_x,
                               w_nxt_data, w_data_spc, w_data_x);
      r_ch       <= w_nxt_ch;
      r_data     <= w_nxt_data;
      r_sop      <= w_nxt_sop;
      r_eop      <= w_nxt_eop;
      if (w_in_acc) begin
        r_hold_valid <= 1'b1;
      end else if (w_final_acc) begin
        r_hold_valid <= 1'b0;
      end else begin
        r_hold_valid <= r_hold_valid;
      end
      if ((r_state == S_CH_VAL) && out_ready) begin
        r_last_ch       <= r_ch;
        r_last_ch_valid <= 1'b1;
      end else begin
        r_last_ch       <= r_last_ch;
        r_last_ch_valid <= r_last_ch_valid;
      end
    end
  end

endmodule

// File: tb/tb_pcie_wrap0_master_0_packets_to_bytes.sv
// Self-checking bench: byte-queue reference model of the framing rules plus
// literal expectations for the directed scenarios.
module tb_pcie_wrap0_master_0_packets_to_bytes;

  localparam int CW     = 8;
  localparam bit RESEND = 1'b0;

  logic          clk = 1'b0;
  logic          reset;
  logic          in_ready;
  logic          in_valid;
  logic [7:0]    in_data;
  logic [CW-1:0] in_channel;
  logic          in_sop;
  logic          in_eop;
  logic          out_ready;
  logic          out_valid;
  logic [7:0]    out_data;

  int         n_tests = 0;
  int         n_fails = 0;
  int         cyc = 0;
  bit         chk_en = 1'b0;
  bit         ready_rand = 1'b0;
  logic       prev_stall = 1'b0;
  logic [7:0] prev_data = 8'h00;
  logic [7:0] exp_q[$];
  logic       m_lcv = 1'b0;
  logic [7:0] m_lc = 8'h00;
  logic [7:0] obs_q[$];
  int         obs_cyc[$];
  logic       obs_rdy[$];

  always #5 clk = ~clk;

  pcie_wrap0_master_0_packets_to_bytes #(
    .CHANNEL_WIDTH         (CW),
    .RESEND_CHANNEL_ON_SOP (RESEND)
  ) dut (
    .clk              (clk),
    .reset            (reset),
    .in_ready         (in_ready),
    .in_valid         (in_valid),
    .in_data          (in_data),
    .in_channel       (in_channel),
    .in_startofpacket (in_sop),
    .in_endofpacket   (in_eop),
    .out_ready        (out_ready),
    .out_valid        (out_valid),
    .out_data         (out_data)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fails++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic void push_esc(input logic [7:0] x);
    if (x >= 8'h7A && x <= 8'h7D) begin
      exp_q.push_back(8'h7D);
      exp_q.push_back(x ^ 8'h20);
    end else begin
      exp_q.push_back(x);
    end
  endfunction

  function automatic void model_beat(input logic [7:0] ch, input logic [7:0] d, input logic s, input logic e);
    if (!m_lcv || ch != m_lc || (RESEND && s)) begin
      exp_q.push_back(8'h7C);
      push_esc(ch);
      m_lc  = ch;
      m_lcv = 1'b1;
    end
    if (s) exp_q.push_back(8'h7A);
    if (e) exp_q.push_back(8'h7B);
    push_esc(d);
  endfunction

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      out_ready = ready_rand ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  // Compare process: handshake signals and every accepted byte against the model
  initial forever begin
    @(negedge clk);
    if (reset) begin
      exp_q.delete();
      m_lcv      = 1'b0;
      prev_stall = 1'b0;
    end else if (chk_en) begin
      chk("out_valid", 32'(out_valid), 32'(exp_q.size() != 0));
      chk("in_ready", 32'(in_ready), 32'((exp_q.size() == 0) || (exp_q.size() == 1 && out_ready)));
      if (prev_stall) chk("stall_hold", {23'd0, out_valid, out_data}, {23'd0, 1'b1, prev_data});
      if (out_valid && out_ready) begin
        obs_q.push_back(out_data);
        obs_cyc.push_back(cyc);
        obs_rdy.push_back(in_ready);
        if (exp_q.size() == 0) chk("extra_byte", 32'(out_data), 32'hFFFF_FFFF);
        else chk("byte", 32'(out_data), 32'(exp_q.pop_front()));
      end
      prev_stall = out_valid && !out_ready;
      prev_data  = out_data;
      if (in_valid && in_ready) model_beat(8'(in_channel), in_data, in_sop, in_eop);
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic send_beat(input logic [7:0] ch, input logic [7:0] d, input logic s, input logic e);
    in_valid   = 1'b1;
    in_channel = ch[CW-1:0];
    in_data    = d;
    in_sop     = s;
    in_eop     = e;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (in_ready) begin
        tick();
        in_valid = 1'b0;
        return;
      end
      tick();
    end
    chk("accept_timeout", 32'd0, 32'd1);
    in_valid = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 2000; i++) begin
      tick();
      if (exp_q.size() == 0 && !out_valid) return;
    end
    chk("drain_timeout", 32'd0, 32'd1);
  endtask

  task automatic clear_obs();
    obs_q.delete();
    obs_cyc.delete();
    obs_rdy.delete();
  endtask

  task automatic check_obs(input string name, input logic [7:0] e[$], input bit consec);
    chk({name, "_count"}, 32'(obs_q.size()), 32'(e.size()));
    for (int i = 0; i < e.size() && i < obs_q.size(); i++) begin
      chk({name, "_byte"}, 32'(obs_q[i]), 32'(e[i]));
      if (consec) chk({name, "_cycle"}, 32'(obs_cyc[i]), 32'(obs_cyc[0] + i));
    end
  endtask

  initial begin
    logic [7:0] e[$];
    logic [7:0] ch;
    logic [7:0] d;
    int         sel;
    reset    = 1'b1;
    in_valid = 1'b0;
    in_data  = 8'h00;
    in_channel = '0;
    in_sop   = 1'b0;
    in_eop   = 1'b0;
    tick();
    tick();
    reset  = 1'b0;
    chk_en = 1'b1;
    @(negedge clk);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_data", 32'(out_data), 32'h00);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    tick();

    // Case 1: SOP+EOP beat on channel 0
    clear_obs();
    send_beat(8'h00, 8'h55, 1'b1, 1'b1);
    drain();
    e = '{8'h7C, 8'h00, 8'h7A, 8'h7B, 8'h55};
    check_obs("case1", e, 1'b1);
    for (int i = 0; i < 5 && i < obs_rdy.size(); i++)
      chk("case1_in_ready", 32'(obs_rdy[i]), 32'(i == 4));

    // Case 2: same channel, special data byte then plain byte
    clear_obs();
    send_beat(8'h00, 8'h7B, 1'b0, 1'b0);
    send_beat(8'h00, 8'h11, 1'b0, 1'b0);
    drain();
    e = '{8'h7D, 8'h5B, 8'h11};
    check_obs("case2", e, 1'b1);

    // Case 3: switch to a channel number that itself needs escaping
    clear_obs();
    send_beat(8'h7D, 8'h01, 1'b1, 1'b0);
    send_beat(8'h7D, 8'h02, 1'b0, 1'b0);
    drain();
    e = '{8'h7C, 8'h7D, 8'h5D, 8'h7A, 8'h01, 8'h02};
    check_obs("case3", e, 1'b1);

    // Case 4: case 1 again from reset with random backpressure
    reset = 1'b1;
    tick();
    reset = 1'b0;
    clear_obs();
    ready_rand = 1'b1;
    send_beat(8'h00, 8'h55, 1'b1, 1'b1);
    drain();
    ready_rand = 1'b0;
    e = '{8'h7C, 8'h00, 8'h7A, 8'h7B, 8'h55};
    check_obs("case4", e, 1'b0);

    // Random beats under random backpressure, model-checked
    ready_rand = 1'b1;
    for (int n = 0; n < 150; n++) begin
      sel = $urandom_range(0, 3);
      ch  = (sel == 0) ? 8'h00 : (sel == 1) ? 8'h01 : (sel == 2) ? 8'h7D : 8'h7A;
      d   = ($urandom_range(0, 3) == 0) ? 8'(8'h7A + $urandom_range(0, 3)) : 8'($urandom_range(0, 255));
      send_beat(ch, d, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end
    drain();
    ready_rand = 1'b0;
    tick();

    // Case 5: 16 back-to-back plain mid-packet beats on an established channel
    send_beat(8'h03, 8'h40, 1'b0, 1'b0);
    drain();
    clear_obs();
    for (int i = 0; i < 16; i++) send_beat(8'h03, 8'(i * 3 + 1), 1'b0, 1'b0);
    drain();
    e.delete();
    for (int i = 0; i < 16; i++) e.push_back(8'(i * 3 + 1));
    check_obs("case5", e, 1'b1);
    for (int i = 0; i < obs_rdy.size(); i++) chk("case5_in_ready", 32'(obs_rdy[i]), 32'd1);

    // Case 6: reset right after the channel marker, then a fresh beat
    clear_obs();
    send_beat(8'h05, 8'h33, 1'b0, 1'b0);
    for (int i = 0; i < 50 && obs_q.size() == 0; i++) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    @(negedge clk);
    chk("case6_valid_after_reset", 32'(out_valid), 32'd0);
    e = '{8'h7C};
    check_obs("case6_trunc", e, 1'b0);
    tick();
    clear_obs();
    send_beat(8'h00, 8'h20, 1'b0, 1'b0);
    drain();
    e = '{8'h7C, 8'h00, 8'h20};
    check_obs("case6", e, 1'b1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fails);
    $finish;
  end

endmodule
